// File: rtl/ysyx_23060061_alu_issue.sv
// Decode/issue stage for the RV32I ALU-class subset. It holds one decoded op in
// an output register and hands it to the execute ALU over a valid/ready handshake.
module ysyx_23060061_alu_issue #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_inst,
  input  logic [WIDTH-1:0]     in_pc,
  input  logic [WIDTH-1:0]     in_rs1_data,
  input  logic [WIDTH-1:0]     in_rs2_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_a,
  output logic [WIDTH-1:0]     out_b,
  output logic [3:0]           out_aluop,
  output logic [4:0]           out_rd,
  output logic                 out_wen,
  output logic [WIDTH-1:0]     out_link,
  output logic                 out_is_jump,
  output logic                 out_illegal,
  output logic [CNT_WIDTH-1:0] issue_cnt
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_PASSB  = 4'b0001;
  localparam logic [3:0] ALU_ADDCLR = 4'b0010;
  localparam logic [3:0] ALU_SUB    = 4'b0011;
  localparam logic [3:0] ALU_SLTU   = 4'b0100;
  localparam logic [3:0] ALU_SLT    = 4'b0101;
  localparam logic [3:0] ALU_XOR    = 4'b0110;
  localparam logic [3:0] ALU_SRA    = 4'b0111;

  logic [6:0]       opcode;
  logic [6:0]       funct7;
  logic [2:0]       funct3;
  logic [4:0]       rdField;
  logic [WIDTH-1:0] immI;
  logic [WIDTH-1:0] immU;
  logic [WIDTH-1:0] immJ;
  logic [WIDTH-1:0] shamt;
  logic [WIDTH-1:0] pcPlus4;

  assign opcode  = in_inst[6:0];
  assign funct3  = in_inst[14:12];
  assign funct7  = in_inst[31:25];
  assign rdField = in_inst[11:7];
  assign immI    = WIDTH'($signed(in_inst[31:20]));
  assign immU    = WIDTH'($signed({in_inst[31:12], 12'b0}));
  assign immJ    = WIDTH'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                   in_inst[30:21], 1'b0}));
  assign shamt   = WIDTH'(in_inst[24:20]);
  assign pcPlus4 = in_pc + WIDTH'(4);

  logic [WIDTH-1:0] decA;
  logic [WIDTH-1:0] decB;
  logic [3:0]       decOp;
  logic             decLegal;
  logic             decJump;

  // Anything not explicitly recognised stays illegal and is forced to a zeroed add.
  always_comb begin
    decA     = '0;
    decB     = '0;
    decOp    = ALU_ADD;
    decLegal = 1'b0;
    decJump  = 1'b0;
    case (opcode)
      OPC_OP: begin
        decA = in_rs1_data;
        decB = in_rs2_data;
        case ({funct7, funct3})
          {F7_BASE, 3'b000}: begin decOp = ALU_ADD;  decLegal = 1'b1; end
          {F7_ALT,  3'b000}: begin decOp = ALU_SUB;  decLegal = 1'b1; end
          {F7_BASE, 3'b010}: begin decOp = ALU_SLT;  decLegal = 1'b1; end
          {F7_BASE, 3'b011}: begin decOp = ALU_SLTU; decLegal = 1'b1; end
          {F7_BASE, 3'b100}: begin decOp = ALU_XOR;  decLegal = 1'b1; end
          {F7_ALT,  3'b101}: begin decOp = ALU_SRA;  decLegal = 1'b1; end
          default: ;
        endcase
      end
      OPC_OPIMM: begin
        decA = in_rs1_data;
        decB = immI;
        case (funct3)
          3'b000: begin decOp = ALU_ADD;  decLegal = 1'b1; end
          3'b010: begin decOp = ALU_SLT;  decLegal = 1'b1; end
          3'b011: begin decOp = ALU_SLTU; decLegal = 1'b1; end
          3'b100: begin decOp = ALU_XOR;  decLegal = 1'b1; end
          3'b101: begin
            decB     = shamt;
            decOp    = ALU_SRA;
            decLegal = (funct7 == F7_ALT);
          end
          default: ;
        endcase
      end
      OPC_LUI: begin
        decB     = immU;
        decOp    = ALU_PASSB;
        decLegal = 1'b1;
      end
      OPC_AUIPC: begin
        decA     = in_pc;
        decB     = immU;
        decLegal = 1'b1;
      end
      OPC_JALR: begin
        decA     = in_rs1_data;
        decB     = immI;
        decOp    = ALU_ADDCLR;
        decJump  = 1'b1;
        decLegal = (funct3 == 3'b000);
      end
      OPC_JAL: begin
        decA     = in_pc;
        decB     = immJ;
        decJump  = 1'b1;
        decLegal = 1'b1;
      end
      default: ;
    endcase
    if (!decLegal) begin
      decA    = '0;
      decB    = '0;
      decOp   = ALU_ADD;
      decJump = 1'b0;
    end
  end

  logic                 valid_q, valid_d;
  logic [WIDTH-1:0]     a_q, b_q, link_q;
  logic [3:0]           aluop_q;
  logic [4:0]           rd_q;
  logic                 wen_q, jump_q, illegal_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 accept;
  logic                 pop;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign pop      = valid_q && out_ready;

  // A simultaneous accept and pop simply overwrites the entry, keeping valid high.
  always_comb begin
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (accept) begin
      valid_d = 1'b1;
      cnt_d   = cnt_q + CNT_WIDTH'(1);
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      aluop_q   <= '0;
      rd_q      <= '0;
      wen_q     <= 1'b0;
      link_q    <= '0;
      jump_q    <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        a_q       <= decA;
        b_q       <= decB;
        aluop_q   <= decOp;
        rd_q      <= rdField;
        wen_q     <= decLegal && (rdField != 5'd0);
        link_q    <= decJump ? pcPlus4 : '0;
        jump_q    <= decJump;
        illegal_q <= !decLegal;
      end
    end
  end

  assign out_valid   = valid_q;
  assign out_a       = a_q;
  assign out_b       = b_q;
  assign out_aluop   = aluop_q;
  assign out_rd      = rd_q;
  assign out_wen     = wen_q;
  assign out_link    = link_q;
  assign out_is_jump = jump_q;
  assign out_illegal = illegal_q;
  assign issue_cnt   = cnt_q;

endmodule

// File: tb/tb_ysyx_23060061_alu_issue.sv
// Bench for the ALU issue stage: fixed decode vectors, stall/reset sequences and a
// randomized handshake run checked against a mnemonic-level reference model.
module tb_ysyx_23060061_alu_issue;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] link;
    logic        jump;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [3:0]  out_aluop;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic [31:0] out_link;
  logic        out_is_jump;
  logic        out_illegal;
  logic [31:0] issue_cnt;

  int errors = 0;
  int checks = 0;

  logic        mValid;
  logic [31:0] mCnt;
  exp_t        mHead;
  vec_t        vecs[$];

  ysyx_23060061_alu_issue #(.WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_aluop(out_aluop), .out_rd(out_rd), .out_wen(out_wen), .out_link(out_link),
    .out_is_jump(out_is_jump), .out_illegal(out_illegal), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input exp_t e);
    checkVal({tag, " valid"}, 32'(out_valid), 32'd1);
    checkVal({tag, " a"}, out_a, e.a);
    checkVal({tag, " b"}, out_b, e.b);
    checkVal({tag, " aluop"}, 32'(out_aluop), 32'(e.op));
    if (!e.ill) checkVal({tag, " rd"}, 32'(out_rd), 32'(e.rd));
    checkVal({tag, " wen"}, 32'(out_wen), 32'(e.wen));
    checkVal({tag, " link"}, out_link, e.link);
    checkVal({tag, " jump"}, 32'(out_is_jump), 32'(e.jump));
    checkVal({tag, " illegal"}, 32'(out_illegal), 32'(e.ill));
  endtask

  // Reference: name the instruction first, then apply the operand rule for that name.
  function automatic exp_t refModel(input logic [31:0] inst, input logic [31:0] pc,
                                    input logic [31:0] rs1, input logic [31:0] rs2);
    exp_t        e;
    string       m;
    logic [31:0] immI, immU, immJ;
    int unsigned f3, f7;
    f3   = inst[14:12];
    f7   = inst[31:25];
    immI = $signed(inst) >>> 20;
    immU = inst & 32'hFFFFF000;
    immJ = (inst[31] ? 32'hFFF00000 : 32'h0) | (32'(inst[19:12]) << 12) |
           (32'(inst[20]) << 11) | (32'(inst[30:21]) << 1);
    m = "ILL";
    case (inst[6:0])
      7'h33: begin
        if (f7 == 0 && f3 == 0) m = "ADD";
        else if (f7 == 32 && f3 == 0) m = "SUB";
        else if (f7 == 0 && f3 == 2) m = "SLT";
        else if (f7 == 0 && f3 == 3) m = "SLTU";
        else if (f7 == 0 && f3 == 4) m = "XOR";
        else if (f7 == 32 && f3 == 5) m = "SRA";
      end
      7'h13: begin
        if (f3 == 0) m = "ADDI";
        else if (f3 == 2) m = "SLTI";
        else if (f3 == 3) m = "SLTIU";
        else if (f3 == 4) m = "XORI";
        else if (f3 == 5 && f7 == 32) m = "SRAI";
      end
      7'h37: m = "LUI";
      7'h17: m = "AUIPC";
      7'h67: if (f3 == 0) m = "JALR";
      7'h6F: m = "JAL";
      default: ;
    endcase
    e = '{a: 0, b: 0, op: 0, rd: inst[11:7], wen: 0, link: 0, jump: 0, ill: 0};
    case (m)
      "ADD":   begin e.a = rs1; e.b = rs2; e.op = 0; end
      "SUB":   begin e.a = rs1; e.b = rs2; e.op = 3; end
      "SLT":   begin e.a = rs1; e.b = rs2; e.op = 5; end
      "SLTU":  begin e.a = rs1; e.b = rs2; e.op = 4; end
      "XOR":   begin e.a = rs1; e.b = rs2; e.op = 6; end
      "SRA":   begin e.a = rs1; e.b = rs2; e.op = 7; end
      "ADDI":  begin e.a = rs1; e.b = immI; e.op = 0; end
      "SLTI":  begin e.a = rs1; e.b = immI; e.op = 5; end
      "SLTIU": begin e.a = rs1; e.b = immI; e.op = 4; end
      "XORI":  begin e.a = rs1; e.b = immI; e.op = 6; end
      "SRAI":  begin e.a = rs1; e.b = 32'(inst[24:20]); e.op = 7; end
      "LUI":   begin e.a = 0; e.b = immU; e.op = 1; end
      "AUIPC": begin e.a = pc; e.b = immU; e.op = 0; end
      "JALR":  begin e.a = rs1; e.b = immI; e.op = 2; e.jump = 1; e.link = pc + 4; end
      "JAL":   begin e.a = pc; e.b = immJ; e.op = 0; e.jump = 1; e.link = pc + 4; end
      default: e.ill = 1;
    endcase
    e.wen = !e.ill && (inst[11:7] != 0);
    return e;
  endfunction

  function automatic logic [31:0] randInst();
    logic [31:0] w;
    logic [6:0]  opc;
    w = $urandom();
    case ($urandom_range(0, 7))
      0: opc = 7'h33;
      1: opc = 7'h13;
      2: opc = 7'h37;
      3: opc = 7'h17;
      4: opc = 7'h67;
      5: opc = 7'h6F;
      default: return w;
    endcase
    w[6:0] = opc;
    if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    if (opc == 7'h67 && $urandom_range(0, 3) != 0) w[14:12] = 3'b000;
    return w;
  endfunction

  task automatic addVec(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [4:0] rd, input logic wen,
                        input logic [31:0] link, input logic jump, input logic ill);
    vec_t v;
    v.inst = inst; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
    v.e = '{a: a, b: b, op: op, rd: rd, wen: wen, link: link, jump: jump, ill: ill};
    vecs.push_back(v);
  endtask

  // One random cycle: check the held entry against the model, then advance the model.
  task automatic applyStimulus();
    logic iv, ordy;
    @(negedge clk);
    iv  = ($urandom_range(0, 3) != 0);
    ordy = ($urandom_range(0, 2) != 0);
    in_valid = iv;
    out_ready = ordy;
    in_inst = randInst();
    in_pc = $urandom();
    in_rs1_data = $urandom();
    in_rs2_data = $urandom();
    #1;
    checkVal("rnd in_ready", 32'(in_ready), 32'(!mValid || ordy));
    checkVal("rnd out_valid", 32'(out_valid), 32'(mValid));
    checkVal("rnd issue_cnt", issue_cnt, mCnt);
    if (mValid) checkOutput("rnd", mHead);
    if (iv && (!mValid || ordy)) begin
      mHead  = refModel(in_inst, in_pc, in_rs1_data, in_rs2_data);
      mValid = 1'b1;
      mCnt   = mCnt + 1;
    end else if (mValid && ordy) begin
      mValid = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;
    mValid = 1'b0; mCnt = '0; mHead = refModel(32'h0, 0, 0, 0);

    addVec(32'h00500093, 32'h0, 32'h0, 32'h0, 32'h0, 32'h5, 4'h0, 5'd1, 1, 32'h0, 0, 0);
    addVec(32'h402081B3, 32'h4, 32'h7, 32'h9, 32'h7, 32'h9, 4'h3, 5'd3, 1, 32'h0, 0, 0);
    addVec(32'h000100E7, 32'hFFFFFFFC, 32'h80000011, 32'h0, 32'h80000011, 32'h0, 4'h2, 5'd1, 1,
           32'h0, 1, 0);
    addVec(32'h0000007F, 32'h8, 32'h1234, 32'h5678, 32'h0, 32'h0, 4'h0, 5'd0, 0, 32'h0, 0, 1);
    addVec(32'h00500013, 32'hC, 32'h0, 32'h0, 32'h0, 32'h5, 4'h0, 5'd0, 0, 32'h0, 0, 0);
    addVec(32'h123452B7, 32'h10, 32'hAAAA, 32'h0, 32'h0, 32'h12345000, 4'h1, 5'd5, 1, 32'h0, 0, 0);
    addVec(32'h4030D213, 32'h14, 32'h80000000, 32'h0, 32'h80000000, 32'h3, 4'h7, 5'd4, 1,
           32'h0, 0, 0);
    addVec(32'hFFFFF317, 32'h100, 32'h0, 32'h0, 32'h100, 32'hFFFFF000, 4'h0, 5'd6, 1, 32'h0, 0, 0);
    addVec(32'hFFDFF0EF, 32'h200, 32'h0, 32'h0, 32'h200, 32'hFFFFFFFC, 4'h0, 5'd1, 1,
           32'h204, 1, 0);
    addVec(32'hFFF1B113, 32'h0, 32'h5, 32'h0, 32'h5, 32'hFFFFFFFF, 4'h4, 5'd2, 1, 32'h0, 0, 0);
    addVec(32'h0030D213, 32'h0, 32'h77, 32'h0, 32'h0, 32'h0, 4'h0, 5'd4, 0, 32'h0, 0, 1);
    addVec(32'h0020C3B3, 32'h0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hF0F0F0F0, 32'h0FF00FF0, 4'h6,
           5'd7, 1, 32'h0, 0, 0);
    addVec(32'h003120B3, 32'h0, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFE, 32'h3, 4'h5, 5'd1, 1,
           32'h0, 0, 0);
    addVec(32'h000110E7, 32'h40, 32'h9, 32'h0, 32'h0, 32'h0, 4'h0, 5'd1, 0, 32'h0, 0, 1);

    repeat (2) @(negedge clk);
    checkVal("reset out_valid", 32'(out_valid), 32'd0);
    checkVal("reset out_a", out_a, 32'h0);
    checkVal("reset out_b", out_b, 32'h0);
    checkVal("reset issue_cnt", issue_cnt, 32'h0);
    rst_n = 1'b1;

    // Back-to-back vectors with the consumer always ready: no bubbles expected.
    out_ready = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (i > 0) begin
        checkOutput($sformatf("vec%0d", i - 1), vecs[i - 1].e);
        checkVal($sformatf("vec%0d cnt", i - 1), issue_cnt, 32'(i));
        checkVal("flow in_ready", 32'(in_ready), 32'd1);
      end
      in_valid = 1'b1;
      in_inst = vecs[i].inst;
      in_pc = vecs[i].pc;
      in_rs1_data = vecs[i].rs1;
      in_rs2_data = vecs[i].rs2;
    end
    @(negedge clk);
    checkOutput("vecLast", vecs[vecs.size() - 1].e);
    checkVal("vecLast cnt", issue_cnt, 32'(vecs.size()));
    in_valid = 1'b0;

    @(negedge clk);
    in_valid = 1'b1; in_inst = 32'h123452B7; in_pc = 32'h0; in_rs1_data = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) begin
        out_ready = 1'b0;
        in_inst = 32'h4030D213;
        in_rs1_data = 32'h80000000;
      end
      #1;
      checkVal("stall in_ready", 32'(in_ready), 32'd0);
      checkVal("stall b", out_b, 32'h12345000);
      checkVal("stall aluop", 32'(out_aluop), 32'h1);
      checkVal("stall valid", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checkVal("release in_ready", 32'(in_ready), 32'd1);
    checkVal("release b", out_b, 32'h12345000);
    @(negedge clk);
    checkOutput("srai", refModel(32'h4030D213, 32'h0, 32'h80000000, 32'h0));
    checkVal("srai b", out_b, 32'h3);
    checkVal("srai cnt", issue_cnt, 32'(vecs.size() + 2));

    // Asynchronous reset between edges must drop the held op immediately.
    in_inst = 32'h00500093; in_rs1_data = 32'h55;
    @(posedge clk);
    #2;
    checkVal("prerst valid", 32'(out_valid), 32'd1);
    checkVal("prerst a", out_a, 32'h55);
    rst_n = 1'b0;
    #1;
    checkVal("midrst valid", 32'(out_valid), 32'd0);
    checkVal("midrst cnt", issue_cnt, 32'h0);
    checkVal("midrst a", out_a, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    mValid = 1'b0;
    mCnt = '0;

    for (int n = 0; n < 400; n++) applyStimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_23060061_alu_issue.md
Name: ysyx_23060061_alu_issue

Overview:
- Decode/issue stage that drives the execute ALU operand and opcode interface (`a`, `b`, 4-bit `aluOp`).
- Accepts a fetched RV32I instruction, PC and register-file read data over a valid/ready handshake.
- Decodes the ALU-class subset, selects operands, and holds the result in a one-entry output pipeline register feeding the ALU.
- Also flags illegal encodings and counts issued instructions.

Parameters:
- WIDTH, 32, datapath width of PC, operands and immediates.
- CNT_WIDTH, 32, width of the issued-instruction counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  WIDTH  instruction PC.
- in_rs1_data  in  WIDTH  register-file value of inst[19:15].
- in_rs2_data  in  WIDTH  register-file value of inst[24:20].
- out_valid  out  1  issue register holds a valid op.
- out_ready  in  1  ALU/execute consumes this cycle.
- out_a  out  WIDTH  ALU operand a.
- out_b  out  WIDTH  ALU operand b.
- out_aluop  out  4  ALU opcode.
- out_rd  out  5  destination register.
- out_wen  out  1  writeback enable (0 if rd==0 or illegal).
- out_link  out  WIDTH  pc+4 for JAL/JALR, else 0.
- out_is_jump  out  1  JALR or JAL: ALU result is the jump target, `out_link` is written to rd.
- out_illegal  out  1  encoding outside supported subset.
- issue_cnt  out  CNT_WIDTH  number of accepted handshakes.

Behaviour:
- Reset (async on rst_n low, released synchronously): `out_valid` = 0, all `out_*` data = 0, `issue_cnt` = 0.
- Input handshake:
  - `in_ready` = !out_valid || out_ready (combinational, no bubble on back-to-back flow).
  - Accept when in_valid && in_ready; decoded fields load the issue register the same edge.
  - Latency 1 cycle.
- Output handshake:
  - Pop when out_valid && out_ready.
  - If accept and pop happen in the same cycle, the new op replaces the old one and `out_valid` stays 1.
  - Pop without accept clears `out_valid`.
  - While out_valid && !out_ready, all `out_*` are held stable.
- Counter: `issue_cnt` increments by 1 per accept; wraps to 0 at all-ones.
- AluOp encodings:
  - 0000 add
  - 0001 pass b
  - 0010 add then clear bit 0
  - 0011 sub
  - 0100 sltu
  - 0101 slt
  - 0110 xor
  - 0111 sra (ALU masks shift to 5 bits)
- Decode (a / b / aluOp):
  - ADD, ADDI: rs1 / rs2-or-immI / 0000.
  - SUB: rs1 / rs2 / 0011.
  - SLT, SLTI: rs1 / rs2-or-immI / 0101.
  - SLTU, SLTIU: rs1 / rs2-or-immI / 0100. immI is sign-extended, then compared unsigned.
  - XOR, XORI: rs1 / rs2-or-immI / 0110.
  - SRA: rs1 / rs2 / 0111.
  - SRAI: rs1 / zero-extended shamt / 0111; requires inst[31:25]=0100000, else illegal.
  - LUI: 0 / immU / 0001.
  - AUIPC: pc / immU / 0000.
  - JALR: rs1 / immI / 0010; link = pc+4; is_jump = 1.
  - JAL: pc / immJ / 0000; link = pc+4; is_jump = 1.
- Illegal handling: any other opcode/funct3/funct7 combination gives `out_illegal` = 1, `out_wen` = 0, `out_aluop` = 0000, a = b = 0. Still handshaked and counted.
- Arithmetic: pc+4 wraps modulo 2^WIDTH; all immediates sign-extended to WIDTH.
- Reset mid-operation: pending op is discarded, `out_valid` drops immediately (async); the counter is cleared.

Test Plan:
- ADDI x1,x0,5 (0x00500093), rs1=0, out_ready=1 → next cycle `out_valid`=1, a=0, b=5, aluop=0000, rd=1, wen=1, `issue_cnt`=1.
- SUB x3,x1,x2 (0x402081B3), rs1=7, rs2=9 → a=7, b=9, aluop=0011, rd=3.
- LUI x5,0x12345 (0x123452B7) then SRAI x4,x1,3 (0x4030D213, rs1=0x80000000), out_ready held 0 for 3 cycles → LUI outputs (b=0x12345000, aluop=0001) stable; `in_ready`=0; SRAI issues (b=3, aluop=0111) the cycle after out_ready rises.
- JALR x1,0(x2) (0x000100E7), pc=0xFFFFFFFC, rs1=0x80000011 → aluop=0010, b=0, link=0x00000000 (wrap), is_jump=1.
- Opcode 0x0000007F, then ADDI with rd=0 (0x00500013) → first: illegal=1, wen=0; second: wen=0, illegal=0; `issue_cnt`=2.
- Continuous in_valid and out_ready for 8 ops → 8 consecutive out_valid cycles with no bubbles; assert rst_n low mid-stream → `out_valid`=0 and `issue_cnt`=0 before the next edge.
